// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset register bank: S=R=1 resolution
// encodings and the address-width helper.
package sr_pkg;

  localparam int SR_HOLD   = 0;
  localparam int SR_SET    = 1;
  localparam int SR_RESET  = 2;
  localparam int SR_TOGGLE = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sr_word_next.sv
// Combinational next-word rule for one set/reset register word; used both
// for the storage update and for the same-address read bypass.
module sr_word_next
  import sr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SR_MODE = 0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] s_mask,
  input  logic [WIDTH-1:0] r_mask,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] s_only;
  logic [WIDTH-1:0] r_only;
  logic [WIDTH-1:0] base;

  always_comb begin
    both   = s_mask & r_mask;
    s_only = s_mask & ~r_mask;
    r_only = r_mask & ~s_mask;
    // Bits with both requests keep cur here; the mode decides them below.
    base   = (cur | s_only) & ~r_only;
    case (SR_MODE)
      SR_SET:    nxt = base | both;
      SR_RESET:  nxt = base & ~both;
      SR_TOGGLE: nxt = base ^ both;
      default:   nxt = base;
    endcase
  end

endmodule

// File: rtl/sr_reg_bank.sv
// Addressed bank of multi-bit set/reset registers with a registered,
// write-bypassed read port and sticky conflict tracking.
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int SR_MODE = 0,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          s_mask,
  input  logic [WIDTH-1:0]          r_mask,
  input  logic                      re,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rvalid,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt,
  input  logic                      clr_conflict
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wr_next_p0;
  logic [WIDTH-1:0] rd_word_p0;
  logic             hit_p0;

  logic [WIDTH-1:0] rdata_p1;
  logic             vld_p1;
  logic             conflict_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sr_word_next #(
    .WIDTH   (WIDTH),
    .SR_MODE (SR_MODE)
  ) u_next (
    .cur    (mem[waddr]),
    .s_mask (s_mask),
    .r_mask (r_mask),
    .nxt    (wr_next_p0)
  );

  // p0: combinational next word, bypassed read word, conflict detect
  always_comb begin
    rd_word_p0 = (we && (waddr == raddr)) ? wr_next_p0 : mem[raddr];
    hit_p0     = we && (|(s_mask & r_mask));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wr_next_p0;
    end
  end

  // p1: registered read port and conflict tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= re;
      if (re) rdata_p1 <= rd_word_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else if (clr_conflict) begin
      conflict_p1 <= 1'b0;
      cnt_p1      <= '0;
    end else if (hit_p0) begin
      conflict_p1 <= 1'b1;
      cnt_p1      <= sat_inc(cnt_p1);
    end
  end

  assign rdata        = rdata_p1;
  assign rvalid       = vld_p1;
  assign conflict     = conflict_p1;
  assign conflict_cnt = cnt_p1;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Bench for sr_reg_bank: four instances, one per S=R=1 mode, driven in
// lockstep by directed vectors, reset sequences and random traffic.
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [1:0] waddr = '0;
  logic [7:0] s_mask = '0;
  logic [7:0] r_mask = '0;
  logic       re = 1'b0;
  logic [1:0] raddr = '0;
  logic       clr_conflict = 1'b0;

  logic [7:0] rdata    [4];
  logic       rvalid   [4];
  logic       conflict [4];
  logic [1:0] cnt      [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sr_reg_bank #(
      .WIDTH   (8),
      .DEPTH   (4),
      .SR_MODE (g),
      .CNT_W   (2)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .we           (we),
      .waddr        (waddr),
      .s_mask       (s_mask),
      .r_mask       (r_mask),
      .re           (re),
      .raddr        (raddr),
      .rdata        (rdata[g]),
      .rvalid       (rvalid[g]),
      .conflict     (conflict[g]),
      .conflict_cnt (cnt[g]),
      .clr_conflict (clr_conflict)
    );
  end

  // Reference model: per-bit rules applied to plain arrays
  logic [7:0] m_mem [4][4];
  logic [7:0] m_rd  [4];
  logic       m_rv;
  logic       m_conf;
  int         m_cnt;

  function automatic logic [7:0] ref_next(input int mode, input logic [7:0] cur,
                                           input logic [7:0] s, input logic [7:0] r);
    logic [7:0] o;
    for (int b = 0; b < 8; b++) begin
      if (s[b] && !r[b])      o[b] = 1'b1;
      else if (!s[b] && r[b]) o[b] = 1'b0;
      else if (!s[b] && !r[b]) o[b] = cur[b];
      else begin
        case (mode)
          1:       o[b] = 1'b1;
          2:       o[b] = 1'b0;
          3:       o[b] = ~cur[b];
          default: o[b] = cur[b];
        endcase
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      m_rd[m] = 8'h00;
      for (int a = 0; a < 4; a++) m_mem[m][a] = 8'h00;
    end
    m_rv = 1'b0; m_conf = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    for (int m = 0; m < 4; m++) begin
      if (re) m_rd[m] = (we && waddr == raddr) ?
                        ref_next(m, m_mem[m][waddr], s_mask, r_mask) : m_mem[m][raddr];
      if (we) m_mem[m][waddr] = ref_next(m, m_mem[m][waddr], s_mask, r_mask);
    end
    m_rv = re;
    if (clr_conflict) begin
      m_conf = 1'b0; m_cnt = 0;
    end else if (we && (s_mask & r_mask) != 8'h00) begin
      m_conf = 1'b1;
      if (m_cnt < 3) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[mode %0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0][7:0] erd,
                          input logic erv, input logic ec, input logic [1:0] ecnt);
    for (int m = 0; m < 4; m++) begin
      chk({tag, ".rdata"},    m, 32'(rdata[m]),    32'(erd[m]));
      chk({tag, ".rvalid"},   m, 32'(rvalid[m]),   32'(erv));
      chk({tag, ".conflict"}, m, 32'(conflict[m]), 32'(ec));
      chk({tag, ".cnt"},      m, 32'(cnt[m]),      32'(ecnt));
    end
  endtask

  task automatic chk_model(input string tag);
    chk_outs(tag, {m_rd[3], m_rd[2], m_rd[1], m_rd[0]}, m_rv, m_conf, 2'(m_cnt));
  endtask

  task automatic apply(input logic w, input logic [1:0] wa, input logic [7:0] s,
                       input logic [7:0] r, input logic rr, input logic [1:0] ra,
                       input logic c);
    we = w; waddr = wa; s_mask = s; r_mask = r; re = rr; raddr = ra; clr_conflict = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Called at posedge+1: reset rises and falls between edges
  task automatic reset_mid(input string tag);
    #3 rst = 1'b1;
    #1 chk_outs(tag, 32'h0, 1'b0, 1'b0, 2'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] s;
    logic [7:0] r;
    logic       re;
    logic [1:0] ra;
    logic       clr;
    logic [3:0][7:0] erd;
    logic       erv;
    logic       ec;
    logic [1:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] wa, input logic [7:0] s,
                              input logic [7:0] r, input logic rr, input logic [1:0] ra,
                              input logic c, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3,
                              input logic erv, input logic ec, input logic [1:0] ecnt);
    vec_t v;
    v.we = w; v.wa = wa; v.s = s; v.r = r; v.re = rr; v.ra = ra; v.clr = c;
    v.erd[0] = e0; v.erd[1] = e1; v.erd[2] = e2; v.erd[3] = e3;
    v.erv = erv; v.ec = ec; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(1, 2, 8'h0F, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 0, 8'h00, 8'h00, 1, 2, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 1, 0, 0);
    tbl[2]  = mk(1, 2, 8'h00, 8'h03, 1, 2, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 1, 0, 0);
    tbl[3]  = mk(1, 0, 8'hA5, 8'h00, 0, 0, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 0, 0);
    tbl[4]  = mk(1, 0, 8'hFF, 8'hFF, 1, 0, 0, 8'hA5, 8'hFF, 8'h00, 8'h5A, 1, 1, 1);
    tbl[5]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hA5, 8'hFF, 8'h00, 8'h5A, 1, 1, 1);
    tbl[6]  = mk(1, 1, 8'h80, 8'h00, 1, 1, 0, 8'h80, 8'h80, 8'h80, 8'h80, 1, 1, 1);
    tbl[7]  = mk(1, 3, 8'hFF, 8'h00, 0, 0, 0, 8'h80, 8'h80, 8'h80, 8'h80, 0, 1, 1);
    tbl[8]  = mk(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 8'hA5, 8'hFF, 8'h00, 8'h5A, 1, 1, 1);
    tbl[9]  = mk(0, 0, 8'h00, 8'h00, 1, 3, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1);
    tbl[10] = mk(1, 1, 8'h01, 8'h01, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 2);
    tbl[11] = mk(1, 1, 8'h01, 8'h01, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 3);
    tbl[12] = mk(1, 1, 8'h01, 8'h01, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 3);
    tbl[13] = mk(1, 1, 8'h01, 8'h01, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1, 3);
    tbl[14] = mk(1, 1, 8'h01, 8'h01, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0);
    tbl[15] = mk(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h80, 8'h81, 8'h80, 8'h81, 1, 0, 0);

    model_reset();
    @(posedge clk);
    #1;
    reset_mid("reset");
    for (int a = 0; a < 4; a++) begin
      apply(0, 2'd0, 8'h00, 8'h00, 1, 2'(a), 0);
      chk_outs("reset_read", 32'h0, 1'b1, 1'b0, 2'd0);
    end

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].we, tbl[i].wa, tbl[i].s, tbl[i].r, tbl[i].re, tbl[i].ra, tbl[i].clr);
      chk_outs($sformatf("vec%0d", i), tbl[i].erd, tbl[i].erv, tbl[i].ec, tbl[i].ecnt);
    end

    for (int i = 0; i < 400; i++) begin
      logic [7:0] s, r;
      s = 8'($urandom);
      r = ($urandom_range(0, 2) == 0) ? 8'($urandom) & s : 8'($urandom) & ~s;
      apply(($urandom_range(0, 3) != 0), 2'($urandom), s, r,
            ($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 15) == 0));
      chk_model("rand");
    end

    // Write burst into word 2, then reset lands between edges mid-write
    for (int i = 0; i < 3; i++) begin
      apply(1, 2'd2, 8'hFF, 8'h0F, 0, 2'd0, 0);
      chk_model("burst");
    end
    we = 1'b1; waddr = 2'd2; s_mask = 8'h3C; r_mask = 8'h00; re = 1'b1; raddr = 2'd2;
    reset_mid("mid_reset");
    apply(0, 2'd0, 8'h00, 8'h00, 1, 2'd2, 0);
    chk_outs("post_reset_read", 32'h0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            2'($urandom), 1'b0);
      chk_model("post_reset_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
# sr_reg_bank

Parametrised bank of DEPTH set/reset registers, each WIDTH bits, updated per bit from set and reset masks on the rising edge of `clk`. It generalises the single-bit SR flip-flop to addressed, multi-bit words, with a selectable resolution for the forbidden S=R=1 case, a registered read port and conflict tracking. It sits in the CPU memory layer as the flag/status register store that control logic sets and clears bit-wise.

## Interface

Parameters:
- WIDTH, 8: bits per register word
- DEPTH, 4: number of register words; power of two, ≥2
- SR_MODE, 0: S=R=1 resolution; 0 hold, 1 set wins, 2 reset wins, 3 toggle (JK behaviour)
- CNT_W, 8: width of conflict counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- we  in  1  apply masks to word `waddr` this cycle
- waddr  in  log2(DEPTH)  write address
- s_mask  in  WIDTH  per-bit set request
- r_mask  in  WIDTH  per-bit reset request
- re  in  1  read request
- raddr  in  log2(DEPTH)  read address
- rdata  out  WIDTH  registered read data
- rvalid  out  1  high one cycle after an accepted `re`
- conflict  out  1  sticky: some write had s_mask & r_mask ≠ 0
- conflict_cnt  out  CNT_W  number of conflicting writes, saturating
- clr_conflict  in  1  synchronous clear of `conflict` and `conflict_cnt`

## Operation

- Per bit i of word `waddr` when `we`=1: s=0,r=0 hold; s=1,r=0 → 1; s=0,r=1 → 0; s=1,r=1 per SR_MODE.
- Words not addressed, or all words when `we`=0, hold.
- Conflict: a write counts if `we`=1 and (s_mask & r_mask) ≠ 0, regardless of SR_MODE. Counts one per cycle, not per bit.
- `conflict` sets on a conflicting write; `conflict_cnt` increments, saturating at 2^CNT_W−1.
- `clr_conflict` same cycle as a conflicting write: clear wins; both outputs read 0 next cycle.
- Read: `re`=1 captures word `raddr` into `rdata`; `rvalid`=1 for the next cycle. `re`=0: `rdata` holds last value, `rvalid`=0.
- Read-during-write, same address: `rdata` returns the post-update value (write bypass).
- Masks are ignored when `we`=0; no conflict counted.

## Timing

- Write latency: 1 cycle; new word visible to a read issued the cycle after, or the same cycle via bypass.
- Read latency: 1 cycle, `re` at edge n → `rdata`/`rvalid` valid after edge n.
- Full throughput: one write and one read every cycle.
- Reset (async, any time, including mid-sequence): all words 0, `rdata`=0, `rvalid`=0, `conflict`=0, `conflict_cnt`=0, applied immediately without a clock edge. The first edge after `rst` deasserts operates normally.
- No internal state machine beyond the storage, the read register and the counter. Conflict/counter update on the same edge as the write.

## Structure

- Package `sr_pkg`: SR_MODE encodings (SR_HOLD=0, SR_SET=1, SR_RESET=2, SR_TOGGLE=3) and the address-width helper (clog2).
- Sub-module `sr_word_next` (combinational): inputs current word, s_mask, r_mask; output next word per SR_MODE. Shared by the storage update and the read bypass path.
- Top holds the DEPTH×WIDTH storage array, read register, conflict flag and counter.

## Test plan

- Reset/basic: `rst` pulse mid-clock → all reads return 0x00. Write word 2 s=0x0F,r=0 → read 2 = 0x0F. Then s=0,r=0x03 → 0x0C.
- Conflict modes: word=0xA5, s=r=0xFF; SR_MODE 0/1/2/3 → 0xA5/0xFF/0x00/0x5A. `conflict`=1, `conflict_cnt`=1 in every mode.
- Bypass: write word 1 s=0x80 with re, raddr=1 same cycle (prior 0x00) → `rdata`=0x80, `rvalid`=1 next cycle.
- Isolation: write word 3 s=0xFF with we=1; masks 0xFF with we=0 on word 0 → word 0 stays 0x00, word 3=0xFF, `conflict_cnt` unchanged.
- Counter: CNT_W=2, 5 consecutive conflicting writes → cnt 1,2,3,3,3. `clr_conflict` together with a 6th conflicting write → `conflict`=0, cnt=0.
- Async reset mid-operation: assert `rst` between edges during a write burst → outputs 0 before next edge. First post-reset read of a written word = 0x00.
